// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Dynamic conditional-branch predictor. It uses a flop-based table of 2-bit
//   saturating counters and indexes it with pc_IF[IDX_W+1:2]. EX resolves
//   each branch one cycle after its lookup. Training therefore uses the
//   index that was registered at lookup time (idx_q).
//
//   Optional build macro: GSHARE_EN
//     When defined, an IDX_W-bit global history register is XORed into the
//     lookup index. The history register is updated only when EX resolves a
//     branch.
//
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     pc_IF, ir_IF  PC and instruction currently in IF/ID
//     predict       combinational taken prediction
//     upd_en        EX holds a resolved conditional branch
//     upd_taken     actual outcome of that branch
//     upd_predict   prediction that was made for that branch
//     mispredict    combinational: upd_en && (upd_taken != upd_predict)
//     stat_branch   saturating count of resolved branches
//     stat_miss     saturating count of mispredicted branches
// ---------------------------------------------------------------------------

// One table entry: a 2-bit saturating counter.
module branch_predictor_cnt #(
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       taken,
  output logic [1:0] cnt
);
  logic [1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = CNT_INIT;
    end else if (wr) begin
      if (taken) begin
        if (cnt_q != 2'b11) cnt_d = cnt_q + 2'd1;
      end else begin
        if (cnt_q != 2'b00) cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

module branch_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_IF,
  input  logic [31:0] ir_IF,
  output logic        predict,
  input  logic        upd_en,
  input  logic        upd_taken,
  input  logic        upd_predict,
  output logic        mispredict,
  output logic [31:0] stat_branch,
  output logic [31:0] stat_miss
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0][1:0] cnt;
  logic [ENTRIES-1:0]      wr;
  logic [IDX_W-1:0]        idx, idx_d, idx_q;
  logic [31:0]             stat_branch_d, stat_branch_q;
  logic [31:0]             stat_miss_d, stat_miss_q;
  logic                    is_branch;

  assign is_branch = (ir_IF[6:0] == 7'b1100011);

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr_d, ghr_q;

  // History advances only on resolve, so a flushed wrong-path lookup never
  // pollutes it.
  always_comb begin
    ghr_d = ghr_q;
    if (rst)         ghr_d = '0;
    else if (upd_en) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
  end

  always_ff @(posedge clk) ghr_q <= ghr_d;

  assign idx = pc_IF[IDX_W+1:2] ^ ghr_q;
`else
  assign idx = pc_IF[IDX_W+1:2];
`endif

  // The lookup reads the counter before the edge. An update of the same
  // entry in the same cycle becomes visible only on the next lookup.
  assign predict    = is_branch && cnt[idx][1] && !rst;
  assign mispredict = upd_en && (upd_taken != upd_predict);

  // The entry written is always the one that was looked up last cycle.
  // Bubbles and flushes arrive with upd_en=0, so a stale idx_q is harmless.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    assign wr[g] = upd_en && (idx_q == IDX_W'(g));
    branch_predictor_cnt #(.CNT_INIT(CNT_INIT)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .wr   (wr[g]),
      .taken(upd_taken),
      .cnt  (cnt[g])
    );
  end

  always_comb begin
    idx_d         = idx;
    stat_branch_d = stat_branch_q;
    stat_miss_d   = stat_miss_q;
    if (rst) begin
      idx_d         = '0;
      stat_branch_d = '0;
      stat_miss_d   = '0;
    end else begin
      if (upd_en && (stat_branch_q != 32'hFFFF_FFFF))
        stat_branch_d = stat_branch_q + 32'd1;
      if (mispredict && (stat_miss_q != 32'hFFFF_FFFF))
        stat_miss_d = stat_miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    idx_q         <= idx_d;
    stat_branch_q <= stat_branch_d;
    stat_miss_q   <= stat_miss_d;
  end

  assign stat_branch = stat_branch_q;
  assign stat_miss   = stat_miss_q;

  // Only the index field and the opcode are consumed.
  logic unused_bits;
  assign unused_bits = ^{pc_IF[31:IDX_W+2], pc_IF[1:0], ir_IF[31:7]};
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Dynamic conditional-branch predictor that sources the `predict` bit consumed by the ID stage when it selects the next fetch PC. It looks up a table of 2-bit saturating counters indexed by pc_IF. The next cycle, EX returns the resolved outcome (taken / predicted) to train the entry and to flag mispredicts. It also keeps branch and mispredict statistics for the debug path.

Parameters:
IDX_W, 6, table index width; the table holds 2^IDX_W counters.
CNT_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
pc_IF  input  32  PC of the instruction currently in IF/ID
ir_IF  input  32  instruction currently in IF/ID
predict  output  1  combinational; 1 = predict taken
upd_en  input  1  EX holds a resolved conditional branch this cycle
upd_taken  input  1  actual branch outcome from EX
upd_predict  input  1  prediction made for that branch (predict_ID)
mispredict  output  1  combinational; upd_en && (upd_taken != upd_predict)
stat_branch  output  32  registered count of resolved branches
stat_miss  output  32  registered count of mispredicted branches

Behaviour:
- is_branch = (ir_IF[6:0] == 7'b1100011).
- Lookup index idx = pc_IF[IDX_W+1:2]; with GSHARE_EN it is XORed with the GHR.
- predict = is_branch && cnt[idx][1] && !rst.
- Instructions that are not branches (including jal) always give predict=0. The ID stage handles jal itself.
- idx_q: a register that captures idx on every posedge when not in reset.
- A branch looked up in cycle N is resolved in EX in cycle N+1. Training therefore always uses idx_q, never a recomputed index.
- A load-use bubble or flush reaches EX with upd_en=0, so a stale idx_q is never written.
- Update on posedge when upd_en=1:
  - upd_taken=1: cnt[idx_q] increments, saturating at 2'b11.
  - upd_taken=0: cnt[idx_q] decrements, saturating at 2'b00.
- Read/write collision: a lookup in the same cycle as an update to the same entry returns the old value. There is no bypass.
- Statistics on posedge:
  - stat_branch increments when upd_en=1.
  - stat_miss increments when mispredict=1.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- Reset: on the first posedge with rst=1, all of the following are set:
  - every cnt entry = CNT_INIT
  - idx_q = 0
  - GHR = 0
  - stat_branch = 0
  - stat_miss = 0
- While rst is asserted, updates and statistics are ignored. A reset in the middle of a run discards all training.
- Reset values of outputs: predict = 0 while rst=1; stat_branch = 0; stat_miss = 0. mispredict follows its inputs at all times.
- Latency:
  - predict: 0 cycles (same cycle as pc_IF).
  - Training: visible to a lookup 1 cycle after the update edge.
- Storage: flops (an array of 2-bit registers), so that reset clears every entry in a single cycle.

Optional Feature:
GSHARE_EN
- Defined:
  - Adds an IDX_W-bit global history register (GHR).
  - idx = pc_IF[IDX_W+1:2] ^ GHR.
  - On every update edge, GHR <= {GHR[IDX_W-2:0], upd_taken}.
  - The GHR is updated only on resolve (non-speculative) and is reset to 0.
- Undefined: there is no GHR, and idx = pc_IF[IDX_W+1:2].

Test Plan:
- Reset, then present pc_IF=0x100 with ir_IF=beq (opcode 0x63) -> predict=0. stat_branch=0 and stat_miss=0.
- Same PC, upd_en=1, upd_taken=1, upd_predict=0 on two consecutive cycles -> mispredict=1 each cycle. Entry goes 01->10->11; the next lookup of 0x100 gives predict=1; stat_miss=2.
- Drive three more taken updates to the saturated entry -> counter stays at 11. Then one not-taken update -> 10, and predict is still 1.
- ir_IF=addi (opcode 0x13) at a PC whose entry is 11 -> predict=0. Also check that pc 0x100 and pc 0x100+(4<<IDX_W) alias to the same entry.
- Lookup and update of the same entry in the same cycle (entry=01, upd_taken=1) -> predict=0 that cycle, predict=1 the next cycle.
- Train an entry to 11, assert rst for one cycle mid-stream with upd_en=1 -> entry back to 01, stats 0, and the update is ignored.
- With GSHARE_EN: after resolved outcomes T,T,N, GHR=3'b110 in the low bits. pc_IF=0x100 then indexes 0 ^ GHR, and the update trains idx_q.
